// File: rtl/clock_sched_ctrl_if.sv
// Signal bundle between the host/core side and clock_sched_ctrl.
// The controller takes the slave modport; the host register block and Clock core take master.
interface clock_sched_ctrl_if #(
  parameter int DIV_W = 24
);
  logic [DIV_W-1:0] div_val;
  logic             cmd_run;
  logic             cmd_stop;
  logic             cmd_clear;
  logic             cmd_step;
  logic [7:0]       hh;
  logic [7:0]       mm;
  logic [7:0]       ss;
  logic             alarm_en;
  logic [7:0]       alarm_hh;
  logic [7:0]       alarm_mm;
  logic [7:0]       alarm_ss;
  logic             alarm_ack;
  logic             start_r;
  logic             clear;
  logic [7:0]       snap_hh;
  logic [7:0]       snap_mm;
  logic [7:0]       snap_ss;
  logic             snap_valid;
  logic             alarm_irq;
  logic [1:0]       state;

  modport master (
    output div_val, cmd_run, cmd_stop, cmd_clear, cmd_step, hh, mm, ss,
           alarm_en, alarm_hh, alarm_mm, alarm_ss, alarm_ack,
    input  start_r, clear, snap_hh, snap_mm, snap_ss, snap_valid, alarm_irq, state
  );

  modport slave (
    input  div_val, cmd_run, cmd_stop, cmd_clear, cmd_step, hh, mm, ss,
           alarm_en, alarm_hh, alarm_mm, alarm_ss, alarm_ack,
    output start_r, clear, snap_hh, snap_mm, snap_ss, snap_valid, alarm_irq, state
  );
endinterface

// File: rtl/clock_sched_ctrl.sv
// Tick sequencer for the Clock core: programmable-rate start_r pulses, single step, stretched
// clear, fixed-latency hh/mm/ss snapshot and sticky alarm.
module clock_sched_ctrl #(
  parameter int DIV_W = 24,
  parameter int LAT   = 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  clock_sched_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, CLR = 2'b10} state_t;
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } hms_t;

  localparam int               LAT_W   = $clog2(LAT + 1);
  localparam logic [DIV_W-1:0] LAT_DIV = DIV_W'(LAT);
  localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(LAT);

  // Clamping the period to at least LAT keeps each capture ahead of the next tick.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < LAT_DIV) ? LAT_DIV : d;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             start_q, start_d;
  logic             clear_q, clear_d;
  logic             clr_hold_q, clr_hold_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             cap_q, cap_d;
  logic             valid_q, valid_d;
  hms_t             snap_q, snap_d;
  logic             irq_q, irq_d;
  logic             abort;
  logic             busy;
  logic             match;

  assign busy  = start_q | (lat_q != '0);
  assign match = bus.alarm_en &&
                 ({bus.hh, bus.mm, bus.ss} == {bus.alarm_hh, bus.alarm_mm, bus.alarm_ss});

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    div_d      = div_q;
    presc_d    = presc_q;
    start_d    = 1'b0;
    clear_d    = 1'b0;
    clr_hold_d = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_clear) begin
          state_d = CLR;
          clear_d = 1'b1;
          abort   = 1'b1;
        end else if (!bus.cmd_stop) begin
          if (bus.cmd_run) begin
            state_d = RUN;
            div_d   = bus.div_val;
            presc_d = eff_div(bus.div_val);
          end else if (bus.cmd_step && !busy) begin
            start_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.cmd_clear) begin
          state_d = CLR;
          clear_d = 1'b1;
          abort   = 1'b1;
        end else if (bus.cmd_stop) begin
          state_d = IDLE;
        end else if (presc_q == '0) begin
          start_d = 1'b1;
          presc_d = eff_div(div_q);
        end else begin
          presc_d = presc_q - DIV_W'(1);
        end
      end
      CLR: begin
        abort = 1'b1;
        if (clr_hold_q) begin
          state_d = IDLE;
        end else begin
          clear_d    = 1'b1;
          clr_hold_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture pipeline: load LAT when start_r falls, sample the core when the count runs out.
  always_comb begin
    lat_d   = lat_q;
    cap_d   = 1'b0;
    valid_d = cap_q;
    snap_d  = snap_q;
    irq_d   = irq_q & ~bus.alarm_ack;
    if (abort) begin
      lat_d   = '0;
      valid_d = 1'b0;
      snap_d  = '0;
    end else if (start_q) begin
      lat_d = LAT_CNT;
    end else if (lat_q != '0) begin
      lat_d = lat_q - LAT_W'(1);
      if (lat_q == LAT_W'(1)) begin
        cap_d  = 1'b1;
        snap_d = '{hh: bus.hh, mm: bus.mm, ss: bus.ss};
        if (match) irq_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register here,
  // snapshot included, takes a defined value on reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      presc_q    <= '0;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      clr_hold_q <= 1'b0;
      lat_q      <= '0;
      cap_q      <= 1'b0;
      valid_q    <= 1'b0;
      snap_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      start_q    <= start_d;
      clear_q    <= clear_d;
      clr_hold_q <= clr_hold_d;
      lat_q      <= lat_d;
      cap_q      <= abort ? 1'b0 : cap_d;
      valid_q    <= valid_d;
      snap_q     <= snap_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.start_r    = start_q;
  assign bus.clear      = clear_q;
  assign bus.snap_hh    = snap_q.hh;
  assign bus.snap_mm    = snap_q.mm;
  assign bus.snap_ss    = snap_q.ss;
  assign bus.snap_valid = valid_q;
  assign bus.alarm_irq  = irq_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_clock_sched_ctrl.sv
// Scoreboard bench for clock_sched_ctrl: an event-level model predicts tick, snapshot, clear,
// state and alarm behaviour; a monitor compares whatever the DUT presents.
module tb_clock_sched_ctrl;
  localparam int DIV_W = 24;
  localparam int LAT   = 2;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  clock_sched_ctrl_if #(.DIV_W(DIV_W)) bus ();

  clock_sched_ctrl #(.DIV_W(DIV_W), .LAT(LAT)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  // Clock core stub: seconds count up once per tick; hours and minutes stay zero.
  logic [7:0] core_ss;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)        core_ss <= 8'd0;
    else if (bus.clear)   core_ss <= 8'd0;
    else if (bus.start_r) core_ss <= core_ss + 8'd1;
  end
  assign bus.hh = 8'd0;
  assign bus.mm = 8'd0;
  assign bus.ss = core_ss;

  typedef struct {
    int at;
    int ss;
  } snap_t;

  int    tests = 0;
  int    fails = 0;
  int    edge_no = 0;
  int    last_e = 0;
  bit    mon_en = 1'b0;

  // Reference model state
  bit    running = 1'b0;
  int    dval = 0;
  int    next_tick = 0;
  int    clr_end = -1;
  int    cap_edge = -1;
  int    m_ss = 0;
  bit    m_irq = 1'b0;
  int    tick_q[$];
  int    clear_q[$];
  snap_t snap_q[$];
  bit    exp_irq[int];

  bit    clear_prev = 1'b0;
  int    clear_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic int eff(input int d);
    return (d < LAT) ? LAT : d;
  endfunction

  task automatic model_reset();
    running  = 1'b0;
    clr_end  = -1;
    cap_edge = -1;
    m_ss     = 0;
    m_irq    = 1'b0;
    tick_q.delete();
    clear_q.delete();
    snap_q.delete();
    exp_irq.delete();
    clear_prev = 1'b0;
    clear_len  = 0;
  endtask

  // Predict what happens at edge e from the command/alarm inputs now on the bus.
  task automatic model_step(input int e);
    bit tick_now;
    bit set_irq;
    tick_now = 1'b0;
    set_irq  = 1'b0;
    if (e <= clr_end) begin
      // commands ignored while clearing
    end else if (bus.cmd_clear) begin
      clr_end  = e + 2;
      running  = 1'b0;
      cap_edge = -1;
      m_ss     = 0;
      snap_q.delete();
      clear_q.push_back(e);
    end else if (bus.cmd_stop) begin
      running = 1'b0;
    end else if (running) begin
      tick_now = (e == next_tick);
    end else if (bus.cmd_run) begin
      running   = 1'b1;
      dval      = eff(int'(bus.div_val));
      next_tick = e + dval + 1;
    end else if (bus.cmd_step && cap_edge < e) begin
      tick_now = 1'b1;
    end
    if (cap_edge == e)
      set_irq = bus.alarm_en && bus.alarm_hh == 8'd0 && bus.alarm_mm == 8'd0 && int'(bus.alarm_ss) == m_ss;
    m_irq = set_irq ? 1'b1 : (bus.alarm_ack ? 1'b0 : m_irq);
    exp_irq[e] = m_irq;
    if (tick_now) begin
      m_ss = (m_ss + 1) % 256;
      tick_q.push_back(e);
      cap_edge = e + 1 + LAT;
      snap_q.push_back('{at: e + LAT + 2, ss: m_ss});
      if (running) next_tick = e + dval + 1;
    end
  endtask

  task automatic drive(input bit clr, input bit stp, input bit run, input bit stepc,
                       input int dv, input bit ack);
    @(negedge ap_clk);
    bus.cmd_clear = clr;
    bus.cmd_stop  = stp;
    bus.cmd_run   = run;
    bus.cmd_step  = stepc;
    bus.div_val   = DIV_W'(dv);
    bus.alarm_ack = ack;
    last_e = edge_no + 1;
    model_step(last_e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic set_alarm(input bit en, input int mm, input int ss);
    @(negedge ap_clk);
    bus.alarm_en = en;
    bus.alarm_mm = 8'(mm);
    bus.alarm_ss = 8'(ss);
    bus.cmd_clear = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_run = 1'b0; bus.cmd_step = 1'b0;
    bus.alarm_ack = 1'b0;
    last_e = edge_no + 1;
    model_step(last_e);
  endtask

  task automatic monitor_edge(input int e);
    snap_t s;
    int    t;
    int    exp_state;
    while (tick_q.size() > 0 && tick_q[0] < e) begin
      check("tick_missing", e, tick_q[0]);
      void'(tick_q.pop_front());
    end
    if (bus.start_r) begin
      t = (tick_q.size() > 0) ? tick_q[0] : -1;
      check("tick_edge", e, t);
      if (t == e) void'(tick_q.pop_front());
    end
    while (snap_q.size() > 0 && snap_q[0].at < e) begin
      check("snap_missing", e, snap_q[0].at);
      void'(snap_q.pop_front());
    end
    if (bus.snap_valid) begin
      if (snap_q.size() > 0) s = snap_q[0];
      else s = '{at: -1, ss: 0};
      check("snap_edge", e, s.at);
      if (s.at == e) begin
        void'(snap_q.pop_front());
        check("snap_ss", bus.snap_ss, s.ss);
        check("snap_hhmm", {bus.snap_hh, bus.snap_mm}, 0);
      end
    end
    while (clear_q.size() > 0 && clear_q[0] < e) begin
      check("clear_missing", e, clear_q[0]);
      void'(clear_q.pop_front());
    end
    if (bus.clear) begin
      if (!clear_prev) begin
        t = (clear_q.size() > 0) ? clear_q[0] : -1;
        check("clear_edge", e, t);
        if (t == e) void'(clear_q.pop_front());
        check("clear_snap_zero", {bus.snap_valid, bus.snap_hh, bus.snap_mm, bus.snap_ss}, 0);
        check("clear_start_r", bus.start_r, 0);
        clear_len = 0;
      end
      clear_len++;
    end else if (clear_prev) begin
      check("clear_len", clear_len, 2);
    end
    clear_prev = bus.clear;
    exp_state = (e < clr_end) ? 2 : (running ? 1 : 0);
    check("state", bus.state, exp_state);
    if (exp_irq.exists(e)) begin
      check("alarm_irq", bus.alarm_irq, exp_irq[e]);
      exp_irq.delete(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      edge_no++;
      if (mon_en) monitor_edge(edge_no);
    end
  end

  initial begin
    int r;
    bus.cmd_clear = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_run = 1'b0; bus.cmd_step = 1'b0;
    bus.div_val = '0; bus.alarm_ack = 1'b0; bus.alarm_en = 1'b0;
    bus.alarm_hh = 8'd0; bus.alarm_mm = 8'd0; bus.alarm_ss = 8'd0;

    // Reset values
    repeat (3) @(negedge ap_clk);
    check("rst_start_r", bus.start_r, 0);
    check("rst_clear", bus.clear, 0);
    check("rst_snap", {bus.snap_valid, bus.snap_hh, bus.snap_mm, bus.snap_ss}, 0);
    check("rst_irq", bus.alarm_irq, 0);
    check("rst_state", bus.state, 0);
    ap_rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Periodic ticking, div_val=4 -> period 5
    drive(0, 0, 1, 0, 4, 0);
    idle(20);
    drive(0, 1, 0, 0, 0, 0);
    idle(6);

    // div_val=0 clamps to LAT -> period 3
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 0, 1, 0, 0, 0);
    idle(15);
    drive(0, 1, 0, 0, 0, 0);
    idle(6);

    // Three single steps from IDLE
    repeat (3) begin
      drive(0, 0, 0, 1, 0, 0);
      idle(9);
    end

    // Clear and stop together while running
    drive(0, 0, 1, 0, 3, 0);
    idle(8);
    drive(1, 1, 0, 0, 0, 0);
    idle(6);

    // Alarm at 00:00:03, then ack coinciding with a second match, then a lone ack
    set_alarm(1'b1, 0, 3);
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    repeat (3) begin
      drive(0, 0, 0, 1, 0, 0);
      idle(5);
    end
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    repeat (2) begin
      drive(0, 0, 0, 1, 0, 0);
      idle(5);
    end
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10 && last_e + 1 != cap_edge; k++) idle(1);
    check("ack_align", last_e + 1, cap_edge);
    drive(0, 0, 0, 0, 0, 1);
    idle(3);
    drive(0, 0, 0, 0, 0, 1);
    idle(3);

    // Randomized command mix
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0)
        set_alarm(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 4));
      r = $urandom_range(0, 99);
      drive(r < 2, r >= 2 && r < 5, r >= 5 && r < 12, r >= 12 && r < 20,
            $urandom_range(0, 6), $urandom_range(0, 7) == 0);
    end
    drive(0, 1, 0, 0, 0, 0);
    idle(15);
    check("tick_q_drained", tick_q.size(), 0);
    check("snap_q_drained", snap_q.size(), 0);
    check("clear_q_drained", clear_q.size(), 0);

    // Async reset in the middle of a clear, with the alarm flag set
    set_alarm(1'b1, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 0, 0, 1, 0, 0);
    idle(6);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge ap_clk);
    #2;
    mon_en = 1'b0;
    check("pre_rst_clear", bus.clear, 1);
    check("pre_rst_irq", bus.alarm_irq, 1);
    ap_rst_n = 1'b0;
    #1;
    check("arst_clear", bus.clear, 0);
    check("arst_start_r", bus.start_r, 0);
    check("arst_irq", bus.alarm_irq, 0);
    check("arst_snap", {bus.snap_valid, bus.snap_hh, bus.snap_mm, bus.snap_ss}, 0);
    check("arst_state", bus.state, 0);
    bus.cmd_clear = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(20);
    check("post_rst_ticks", tick_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
